// File: rtl/accumulator.sv
// Multiplier by repeated addition: RES = A*B, one addition per enabled cycle.
// Three-state control (IDLE/RUN/DONE) with a registered result that only updates in DONE.
module accumulator #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic           inc,
  output logic [2*W-1:0] RES,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_cnt;
  logic [2*W-1:0]   r_acc;
  logic [2*W-1:0]   r_res;
  logic             w_accept;
  logic             w_step;

  assign w_accept = (r_state == IDLE) && start;
  assign w_step   = (r_state == RUN) && inc && (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (inc && (r_cnt == '0)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      RUN:     busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath; RES captures acc only on the RUN->DONE edge so partial sums never show.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_cnt <= '0;
      r_acc <= '0;
      r_res <= '0;
    end else if (w_accept) begin
      r_a   <= A;
      r_cnt <= B;
      r_acc <= '0;
    end else if (w_step) begin
      r_acc <= r_acc + {{W{1'b0}}, r_a};
      r_cnt <= r_cnt - 1'b1;
    end else if ((r_state == RUN) && inc) begin
      r_res <= r_acc;
    end
  end

  assign RES = r_res;

endmodule

// File: tb/tb_accumulator.sv
// Directed bench for accumulator: edges are counted from the edge that accepts start (edge 1).
// Each scenario task drives its own vectors and compares against hand-computed values.
module tb_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  A = '0;
  logic [7:0]  B = '0;
  logic        inc = 1'b0;
  logic [15:0] RES;
  logic        busy;
  logic        done;

  int vecs = 0;
  int errs = 0;

  accumulator #(.W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .inc  (inc),
    .RES  (RES),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; inc = 1'b1; A = 8'd6; B = 8'd6;
    step();
    step();
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || RES !== 16'd0) begin
      errs++;
      $display("FAIL reset_state: busy=%b done=%b RES=%0d, want busy=0 done=0 RES=0", busy, done, RES);
    end
    rst = 1'b0;
    step();
    vecs++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL first_start_after_reset: busy=%b, want 1", busy);
    end
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || RES !== 16'd0) begin
      errs++;
      $display("FAIL reset_abort: busy=%b done=%b RES=%0d, want 0 0 0", busy, done, RES);
    end
    for (int e = 0; e < 10; e++) begin
      step();
      if (done !== 1'b0) begin
        vecs++; errs++;
        $display("FAIL reset_abort_no_done: done=%b at cycle %0d, want 0", done, e);
      end
    end
  endtask

  task automatic test_basic();
    A = 8'd5; B = 8'd3; inc = 1'b1; start = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      start = 1'b0;
      vecs++;
      if (done !== (e == 5) || busy !== (e <= 5)) begin
        errs++;
        $display("FAIL basic_timing edge %0d: done=%b busy=%b, want done=%b busy=%b",
                 e, done, busy, (e == 5), (e <= 5));
      end
      if (e == 5) begin
        vecs++;
        if (RES !== 16'd15) begin
          errs++;
          $display("FAIL basic_res: RES=%0d, want 15", RES);
        end
      end
    end
  endtask

  task automatic test_max();
    int done_edge;
    done_edge = -1;
    A = 8'hFF; B = 8'hFF; inc = 1'b1; start = 1'b1;
    for (int e = 1; e <= 300 && done_edge < 0; e++) begin
      step();
      start = 1'b0;
      if (done === 1'b1) done_edge = e;
      else if (RES !== 16'd15) begin
        vecs++; errs++;
        $display("FAIL max_partial_sum edge %0d: RES=%0d, want held 15", e, RES);
      end
    end
    vecs++;
    if (done_edge != 257) begin
      errs++;
      $display("FAIL max_latency: done on edge %0d, want 257", done_edge);
    end
    vecs++;
    if (RES !== 16'hFE01) begin
      errs++;
      $display("FAIL max_res: RES=%h, want fe01", RES);
    end
    step();
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || RES !== 16'hFE01) begin
      errs++;
      $display("FAIL max_after_done: busy=%b done=%b RES=%h, want 0 0 fe01", busy, done, RES);
    end
  endtask

  task automatic test_zero();
    A = 8'd9; B = 8'd0; inc = 1'b1; start = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      start = 1'b0;
      vecs++;
      if (done !== (e == 2) || (e == 2 && RES !== 16'd0)) begin
        errs++;
        $display("FAIL zero_count edge %0d: done=%b RES=%0d, want done=%b RES=0", e, done, RES, (e == 2));
      end
    end
    A = 8'd0; B = 8'd4; start = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      start = 1'b0;
      vecs++;
      if (done !== (e == 6) || (e == 6 && RES !== 16'd0)) begin
        errs++;
        $display("FAIL zero_addend edge %0d: done=%b RES=%0d, want done=%b RES=0", e, done, RES, (e == 6));
      end
    end
  endtask

  task automatic test_stall();
    A = 8'd7; B = 8'd2; inc = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    inc = 1'b0; start = 1'b1; A = 8'd99; B = 8'd50;
    for (int e = 3; e <= 12; e++) begin
      step();
      vecs++;
      if (busy !== 1'b1 || done !== 1'b0 || RES !== 16'd0) begin
        errs++;
        $display("FAIL stall_hold edge %0d: busy=%b done=%b RES=%0d, want 1 0 0", e, busy, done, RES);
      end
    end
    inc = 1'b1; start = 1'b0;
    for (int e = 13; e <= 15; e++) begin
      step();
      vecs++;
      if (done !== (e == 14) || busy !== (e <= 14)) begin
        errs++;
        $display("FAIL stall_timing edge %0d: done=%b busy=%b, want done=%b busy=%b",
                 e, done, busy, (e == 14), (e <= 14));
      end
    end
    vecs++;
    if (RES !== 16'd14) begin
      errs++;
      $display("FAIL stall_res: RES=%0d, want 14", RES);
    end
  endtask

  task automatic test_reset_midop();
    A = 8'd10; B = 8'd20; inc = 1'b1; start = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      start = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || RES !== 16'd0) begin
      errs++;
      $display("FAIL midop_reset: busy=%b done=%b RES=%0d, want 0 0 0", busy, done, RES);
    end
    for (int e = 0; e < 25; e++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) begin
        vecs++; errs++;
        $display("FAIL midop_no_done cycle %0d: done=%b busy=%b, want 0 0", e, done, busy);
      end
    end
    A = 8'd2; B = 8'd2; start = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      start = 1'b0;
      vecs++;
      if (done !== (e == 4)) begin
        errs++;
        $display("FAIL midop_restart edge %0d: done=%b, want %b", e, done, (e == 4));
      end
    end
    vecs++;
    if (RES !== 16'd4) begin
      errs++;
      $display("FAIL midop_restart_res: RES=%0d, want 4", RES);
    end
  endtask

  task automatic test_back_to_back();
    A = 8'd3; B = 8'd1; inc = 1'b1; start = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      vecs++;
      if (done !== ((e % 4) == 3) || busy !== ((e % 4) != 0)) begin
        errs++;
        $display("FAIL b2b_timing edge %0d: done=%b busy=%b, want done=%b busy=%b",
                 e, done, busy, ((e % 4) == 3), ((e % 4) != 0));
      end
      if (e == 3 || e == 11) begin
        vecs++;
        if (RES !== 16'd3) begin
          errs++;
          $display("FAIL b2b_res edge %0d: RES=%0d, want 3", e, RES);
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_stall();
    test_reset_midop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
